// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read-port arbiter and its clients.
package regfile_pkg;

   localparam int AW       = 5;    // register address width
   localparam int DW       = 32;   // register data width
   localparam int NREG     = 32;   // registers behind the read port
   localparam int ZERO_REG = 0;    // hard-wired zero register

   // Arbiter ownership state
   typedef enum logic [1:0] {
      FREE     = 2'd0,   // plain round-robin
      LOCKED   = 2'd1,   // one requester owns the port for a burst
      COOLDOWN = 2'd2    // one cycle with the previous owner masked out
   } arb_state_e;

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [NREQ-1:0] mask_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   logic [NREQ-1:0] elig;

   assign elig = req_i & mask_i;

   // Walk the priority order ptr, ptr+1, ... (wrapping) and stop at the first hit.
   always_comb begin
      int          pos;
      logic [PW-1:0] pidx;
      logic        found;
      pos   = 0;
      pidx  = '0;
      found = 1'b0;
      gnt_o = '0;
      idx_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = int'(ptr_i) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         pidx = PW'(pos);
         if (!found && elig[pidx]) begin
            found       = 1'b1;
            gnt_o[pidx] = 1'b1;
            idx_o       = pidx;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the regfile's single read port, with bounded
// burst ownership, write forwarding and a hard-wired zero register.
module regfile_read_arbiter #(
   parameter int NREQ     = 4,
   parameter int AW       = regfile_pkg::AW,
   parameter int DW       = regfile_pkg::DW,
   parameter int MAX_LOCK = 8
) (
   input  logic               clock,
   input  logic               ctrl_reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [NREQ-1:0]    gnt,
   output logic [AW-1:0]      rd_sel,
   input  logic [DW-1:0]      rd_data,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [DW-1:0]      wr_data,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data
);

   import regfile_pkg::*;

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_LOCK + 1);

   // Registered arbitration state
   arb_state_e      state_q, state_d;
   logic [PW-1:0]   ptr_q,   ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q,   cnt_d;

   // Registered response
   logic [NREQ-1:0] rsp_valid_q;
   logic [DW-1:0]   rsp_data_q;

   // Owner decode
   logic [NREQ-1:0] owner_oh;
   logic            own_req;
   logic            own_lock;
   logic            at_limit;
   logic            lk_keep;
   logic            lk_limit;
   logic            cool;

   // Picker hookup
   logic [NREQ-1:0] pick_mask;
   logic [PW-1:0]   pick_ptr;
   logic [NREQ-1:0] pick_gnt;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;

   // Current-cycle grant and read path
   logic [NREQ-1:0] gnt_c;
   logic            any_c;
   logic [AW-1:0]   sel_c;
   logic [DW-1:0]   rsp_next;

   function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] i);
      return (int'(i) >= NREQ - 1) ? '0 : i + 1'b1;
   endfunction

   assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
   assign own_req  = req[owner_q];
   assign own_lock = lock[owner_q];
   assign at_limit = int'(cnt_q) >= MAX_LOCK;

   // An owner that still requests either continues its burst or, once the
   // burst is exhausted, is pushed out for the limit cycle and the cooldown.
   assign lk_keep  = (state_q == LOCKED) && own_req && !at_limit;
   assign lk_limit = (state_q == LOCKED) && own_req &&  at_limit;
   assign cool     = (state_q == COOLDOWN);

   // The limit cycle restarts the rotation just after the evicted owner.
   assign pick_mask = (lk_limit || cool) ? ~owner_oh : '1;
   assign pick_ptr  = lk_limit ? ptr_after(owner_q) : ptr_q;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req_i  (req),
      .mask_i (pick_mask),
      .ptr_i  (pick_ptr),
      .gnt_o  (pick_gnt),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   // Grant selection and next-state for pointer, ownership and burst count.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt_c   = '0;
      any_c   = 1'b0;
      if (lk_keep) begin
         gnt_c = owner_oh;
         any_c = 1'b1;
         if (own_lock) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            state_d = FREE;
            cnt_d   = '0;
            ptr_d   = ptr_after(owner_q);
         end
      end else begin
         gnt_c = pick_gnt;
         any_c = pick_any;
         cnt_d = '0;
         if (pick_any) ptr_d = ptr_after(pick_idx);
         if (lk_limit) begin
            state_d = COOLDOWN;
            if (!pick_any) ptr_d = ptr_after(owner_q);
         end else if (cool) begin
            state_d = FREE;
         end else begin
            // FREE, or a LOCKED owner that walked away: ordinary arbitration
            state_d = FREE;
            if (pick_any && lock[pick_idx]) begin
               state_d = LOCKED;
               owner_d = pick_idx;
               cnt_d   = CW'(1);
            end
         end
      end
   end

   // Route the winner's address to the read port.
   always_comb begin
      sel_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_c[i]) sel_c = req_addr[i*AW +: AW];
      end
   end

   // Zero register beats forwarding, forwarding beats the stale array value.
   always_comb begin
      if (int'(sel_c) == ZERO_REG) begin
         rsp_next = '0;
      end else if (wr_en && (wr_addr == sel_c)) begin
         rsp_next = wr_data;
      end else begin
         rsp_next = rd_data;
      end
   end

   assign gnt    = ctrl_reset_n ? gnt_c : '0;
   assign rd_sel = ctrl_reset_n ? sel_c : '0;

   // Arbitration state update; reset drops any ownership.
   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         state_q <= FREE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   // Response register: one-cycle read latency, data held when idle.
   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= gnt_c;
         if (any_c) rsp_data_q <= rsp_next;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Randomized and directed bench for regfile_read_arbiter with a reference model.
module tb_regfile_read_arbiter;

   import regfile_pkg::*;

   localparam int N  = 4;
   localparam int ML = 8;

   logic            clock;
   logic            ctrl_reset_n;
   logic [N-1:0]    req;
   logic [N-1:0]    lock;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    gnt;
   logic [AW-1:0]   rd_sel;
   logic [DW-1:0]   rd_data;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;

   // Environment register file behind the read port
   logic [DW-1:0]   regs [NREG];

   assign rd_data = regs[rd_sel];

   regfile_read_arbiter #(
      .NREQ     (N),
      .AW       (AW),
      .DW       (DW),
      .MAX_LOCK (ML)
   ) dut (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .req          (req),
      .lock         (lock),
      .req_addr     (req_addr),
      .gnt          (gnt),
      .rd_sel       (rd_sel),
      .rd_data      (rd_data),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks;
   int n_fail;

   // Reference model: owner = -1 means nobody holds a burst,
   // cool_who = -1 means nobody is sitting out this cycle.
   int            m_ptr, m_owner, m_burst, m_cool;
   logic [N-1:0]  m_vld;
   logic [DW-1:0] m_data;
   int            e_win, nx_ptr, nx_owner, nx_burst, nx_cool;
   logic [N-1:0]  e_gnt;
   logic [AW-1:0] e_sel;
   int            last_win;

   logic [N-1:0]  obs_gnt, obs_vld;
   logic [AW-1:0] obs_sel;
   logic [DW-1:0] obs_data;
   logic [N-1:0]  seq [12];
   logic [N-1:0]  nxt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] r;
      r = N'(1);
      return r << i;
   endfunction

   function automatic bit bit_of(input logic [N-1:0] v, input int i);
      logic [N-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   function automatic logic [AW-1:0] get_addr(input int i);
      logic [N*AW-1:0] t;
      t = req_addr >> (i * AW);
      return t[AW-1:0];
   endfunction

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      logic [N*AW-1:0] m;
      logic [N*AW-1:0] v;
      m = {{(N*AW-AW){1'b0}}, {AW{1'b1}}} << (i * AW);
      v = {{(N*AW-AW){1'b0}}, a} << (i * AW);
      req_addr = (req_addr & ~m) | v;
   endtask

   // First requester in rotation order from 'start', never returning 'skip'.
   function automatic int rr_find(input int start, input int skip);
      int i;
      for (int k = 0; k < N; k++) begin
         i = (start + k) % N;
         if (bit_of(req, i) && i != skip) return i;
      end
      return -1;
   endfunction

   task automatic model_comb();
      e_win    = -1;
      nx_ptr   = m_ptr;
      nx_owner = -1;
      nx_burst = 0;
      nx_cool  = -1;
      if (ctrl_reset_n) begin
         if (m_owner >= 0 && bit_of(req, m_owner)) begin
            if (m_burst >= ML) begin
               e_win   = rr_find((m_owner + 1) % N, m_owner);
               nx_cool = m_owner;
               nx_ptr  = ((e_win >= 0 ? e_win : m_owner) + 1) % N;
            end else begin
               e_win = m_owner;
               if (bit_of(lock, m_owner)) begin
                  nx_owner = m_owner;
                  nx_burst = m_burst + 1;
               end else begin
                  nx_ptr = (m_owner + 1) % N;
               end
            end
         end else begin
            e_win = rr_find(m_ptr, m_cool);
            if (e_win >= 0) begin
               nx_ptr = (e_win + 1) % N;
               if (bit_of(lock, e_win) && m_cool < 0) begin
                  nx_owner = e_win;
                  nx_burst = 1;
               end
            end
         end
      end
      e_gnt = (e_win >= 0) ? onehot(e_win) : '0;
      e_sel = (e_win >= 0) ? get_addr(e_win) : '0;
   endtask

   task automatic model_update();
      if (!ctrl_reset_n) begin
         m_ptr   = 0;
         m_owner = -1;
         m_burst = 0;
         m_cool  = -1;
         m_vld   = '0;
         m_data  = '0;
      end else begin
         m_ptr   = nx_ptr;
         m_owner = nx_owner;
         m_burst = nx_burst;
         m_cool  = nx_cool;
         m_vld   = e_gnt;
         if (e_win >= 0) begin
            if (e_sel == '0)                         m_data = '0;
            else if (wr_en && wr_addr == e_sel)      m_data = wr_data;
            else                                     m_data = regs[e_sel];
         end
      end
      if (wr_en && wr_addr != '0) regs[wr_addr] = wr_data;
      last_win = e_win;
   endtask

   // One clock: inputs were set at the falling edge; sample, compare, advance.
   task automatic step();
      #1;
      model_comb();
      obs_gnt  = gnt;
      obs_sel  = rd_sel;
      obs_vld  = rsp_valid;
      obs_data = rsp_data;
      check("gnt",       obs_gnt,  e_gnt);
      check("rd_sel",    obs_sel,  e_sel);
      check("rsp_valid", obs_vld,  m_vld);
      check("rsp_data",  obs_data, m_data);
      @(posedge clock);
      #1;
      model_update();
      @(negedge clock);
   endtask

   task automatic drive_random();
      for (int i = 0; i < N; i++) begin
         bit cur;
         cur = bit_of(req, i);
         if (!cur || last_win == i) begin
            if ($urandom_range(0, 99) < ((last_win == i) ? 80 : 30)) begin
               req = req | onehot(i);
               set_addr(i, ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, NREG - 1)));
            end else begin
               req = req & ~onehot(i);
            end
         end else if ($urandom_range(0, 99) < 4) begin
            req = req & ~onehot(i);
         end
         if ($urandom_range(0, 99) < 85) lock = lock | onehot(i);
         else                            lock = lock & ~onehot(i);
      end
      wr_en = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) wr_addr = get_addr(int'($urandom_range(0, N - 1)));
      else                           wr_addr = AW'($urandom_range(0, NREG - 1));
      wr_data      = $urandom;
      ctrl_reset_n = ($urandom_range(0, 149) != 0);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      ctrl_reset_n = 1'b0;
      req          = '0;
      lock         = '0;
      req_addr     = '0;
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      for (int i = 0; i < NREG; i++) regs[i] = $urandom;
      regs[0]  = 32'hBAD0_BAD0;
      m_ptr    = 0;
      m_owner  = -1;
      m_burst  = 0;
      m_cool   = -1;
      m_vld    = '0;
      m_data   = '0;
      last_win = -1;
      repeat (2) @(negedge clock);

      // Reset holds grant and read select low even with everyone requesting
      req = '1;
      for (int i = 0; i < N; i++) set_addr(i, AW'(i + 1));
      step();
      check("rst_gnt",  obs_gnt,  '0);
      check("rst_sel",  obs_sel,  '0);
      check("rst_vld",  obs_vld,  '0);
      check("rst_data", obs_data, '0);

      // Round-robin rotation with all four requesting
      ctrl_reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         check("rot_gnt", obs_gnt, onehot(k % N));
         if (k > 0) check("rot_vld", obs_vld, onehot((k - 1) % N));
      end

      // Data return: requester 2 reads register 7
      req = onehot(2);
      set_addr(2, 5'd7);
      regs[7] = 32'hDEAD_BEEF;
      step();
      check("dr_gnt", obs_gnt, 4'b0100);
      check("dr_sel", obs_sel, 5'd7);
      req = '0;
      step();
      check("dr_vld",  obs_vld,  4'b0100);
      check("dr_data", obs_data, 32'hDEAD_BEEF);

      // Same-cycle write to the address being read is forwarded
      req = onehot(0);
      set_addr(0, 5'd5);
      regs[5] = 32'hA5A5_5A5A;
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'h1234_5678;
      step();
      // Register 0 reads zero even while being written
      set_addr(0, 5'd0);
      wr_addr = 5'd0;
      wr_data = 32'hFFFF_FFFF;
      step();
      check("fwd_vld",  obs_vld,  4'b0001);
      check("fwd_data", obs_data, 32'h1234_5678);
      req   = '0;
      wr_en = 1'b0;
      step();
      check("zero_vld",  obs_vld,  4'b0001);
      check("zero_data", obs_data, 32'h0);

      // Lock limit: requester 1 bursts while requester 3 waits
      ctrl_reset_n = 1'b0;
      step();
      ctrl_reset_n = 1'b1;
      req  = 4'b1010;
      lock = 4'b0010;
      set_addr(1, 5'd9);
      set_addr(3, 5'd11);
      for (int c = 0; c < 12; c++) begin
         step();
         seq[c] = obs_gnt;
         if (obs_gnt[3]) req[3] = 1'b0;
      end
      for (int c = 0; c < 8; c++) check("lk_own", seq[c], 4'b0010);
      check("lk_cool", seq[8], 4'b1000);
      nxt = '0;
      for (int c = 9; c < 12; c++) if (nxt == '0 && seq[c] != '0) nxt = seq[c];
      check("lk_regain", nxt, 4'b0010);

      // Reset in the middle of a burst abandons ownership
      ctrl_reset_n = 1'b0;
      req[0] = 1'b1;
      set_addr(0, 5'd3);
      step();
      check("rml_gnt", obs_gnt, '0);
      check("rml_sel", obs_sel, '0);
      ctrl_reset_n = 1'b1;
      step();
      check("rml_vld",  obs_vld,  '0);
      check("rml_data", obs_data, '0);
      check("rml_gnt0", obs_gnt,  4'b0001);

      // Randomized traffic against the model
      req      = '0;
      lock     = '0;
      wr_en    = 1'b0;
      last_win = -1;
      for (int t = 0; t < 3000; t++) begin
         drive_random();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
